// File: rtl/clock_disp_pkg.sv
// Shared types, segment constants and the nibble-to-segment function for the clock display path.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_ERR = 7'h79;

  typedef struct packed {
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } time_snap_t;

  localparam time_snap_t SNAP_RST = '{pm: 1'b0, hh: 8'h12, mm: 8'h00, ss: 8'h00};

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] seg_v;
    case (nib)
      4'd0:    seg_v = SEG_0;
      4'd1:    seg_v = SEG_1;
      4'd2:    seg_v = SEG_2;
      4'd3:    seg_v = SEG_3;
      4'd4:    seg_v = SEG_4;
      4'd5:    seg_v = SEG_5;
      4'd6:    seg_v = SEG_6;
      4'd7:    seg_v = SEG_7;
      4'd8:    seg_v = SEG_8;
      4'd9:    seg_v = SEG_9;
      default: seg_v = SEG_ERR;
    endcase
    return seg_v;
  endfunction

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show 'E'.
module bcd7seg_dec
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = bcd_to_seg(i_nib);

endmodule

// File: rtl/clock_digit_scan.sv
// Six-digit multiplexed 7-segment scanner for a 12-hour BCD clock with per-frame snapshot.
// Optional build macro CLOCK_SCAN_BLINK_EN: separator dots blink with seconds LSB.
module clock_digit_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pm,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [5:0] digit_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  time_snap_t    r_snap;
  logic          r_first;
  logic [5:0]    r_digit_sel;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  time_snap_t    w_in;
  time_snap_t    w_snap;
  logic          w_cnt_last;
  logic          w_frame_end;
  logic          w_blank;
  logic          w_sep_dp;
  logic [3:0]    w_nib;
  logic [6:0]    w_dec;
  logic [5:0]    w_sel_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  assign w_in        = {pm, hh, mm, ss};
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_last && (r_idx == IDX_LAST);
  assign w_blank     = (r_cnt < BLANK_LIM);
  // The first post-reset cycle displays the values being captured, not the reset snapshot.
  assign w_snap      = r_first ? w_in : r_snap;

`ifdef CLOCK_SCAN_BLINK_EN
  assign w_sep_dp = ~w_snap.ss[0];
`else
  assign w_sep_dp = 1'b1;
`endif

  // Select the BCD nibble for the active digit.
  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      3'd0:    w_nib = w_snap.ss[3:0];
      3'd1:    w_nib = w_snap.ss[7:4];
      3'd2:    w_nib = w_snap.mm[3:0];
      3'd3:    w_nib = w_snap.mm[7:4];
      3'd4:    w_nib = w_snap.hh[3:0];
      3'd5:    w_nib = w_snap.hh[7:4];
      default: w_nib = 4'h0;
    endcase
  end

  bcd7seg_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Next output values: dead time, leading-zero blanking and dot rules.
  always_comb begin
    w_sel_nxt = 6'h00;
    w_seg_nxt = 7'h00;
    w_dp_nxt  = 1'b0;
    if (!w_blank) begin
      w_sel_nxt = 6'h01 << r_idx;
      if ((r_idx == IDX_LAST) && (w_snap.hh[7:4] == 4'h0)) begin
        w_seg_nxt = 7'h00;
      end else begin
        w_seg_nxt = w_dec;
      end
      case (r_idx)
        3'd0:       w_dp_nxt = w_snap.pm;
        3'd2, 3'd4: w_dp_nxt = w_sep_dp;
        default:    w_dp_nxt = 1'b0;
      endcase
    end else begin
      w_sel_nxt = 6'h00;
      w_seg_nxt = 7'h00;
      w_dp_nxt  = 1'b0;
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? 3'd0 : (r_idx + 3'd1);
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Frame snapshot, taken at frame end and on the first edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap  <= SNAP_RST;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (r_first || w_frame_end) begin
        r_snap <= w_in;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_sel   <= 6'h00;
      r_seg         <= 7'h00;
      r_dp          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_digit_sel   <= w_sel_nxt;
      r_seg         <= w_seg_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= (r_cnt == '0) && (r_idx == 3'd0);
    end
  end

  assign digit_sel   = r_digit_sel;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule
